// File: rtl/dmem_mmio.sv
// Data-side memory: word RAM plus an MMIO block (TX byte FIFO, GPIO, compare timer).
// Define DMEM_TIMER_EN to build the timer; without it the timer offsets read 0 and timer_irq is 0.
module dmem_mmio #(
    parameter int RAM_AW   = 10,
    parameter int TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] data_addr,
    input  logic [31:0] data_in,
    input  logic        mem_we,
    input  logic        mem_re,
    output logic [31:0] data_out,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    output logic [31:0] gpio_out,
    output logic        timer_irq
);

    localparam int PTR_W = $clog2(TX_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [2:0] OFF_TX_DATA    = 3'd0;
    localparam logic [2:0] OFF_TX_STATUS  = 3'd1;
    localparam logic [2:0] OFF_GPIO       = 3'd2;
    localparam logic [2:0] OFF_TMR_COUNT  = 3'd3;
    localparam logic [2:0] OFF_TMR_CMP    = 3'd4;
    localparam logic [2:0] OFF_TMR_STATUS = 3'd5;

    // Address decode
    logic              sel_ram;
    logic              sel_mmio;
    logic [2:0]        mmio_off;
    logic [RAM_AW-1:0] ram_idx;
    logic              mmio_we;
    logic              unused_addr;

    assign sel_ram     = (data_addr[31:28] == 4'h0);
    assign sel_mmio    = (data_addr[31:28] == 4'h1);
    assign mmio_off    = data_addr[4:2];
    assign ram_idx     = data_addr[RAM_AW+1:2];
    assign mmio_we     = mem_we && sel_mmio;
    assign unused_addr = ^data_addr[27:0];

    // Word RAM
    logic [31:0] ram [1 << RAM_AW];

    // NOTE: RAM arrays are deliberately left out of reset so they map onto block RAM.
    always_ff @(posedge clk) begin
        if (mem_we && sel_ram)
            ram[ram_idx] <= data_in;
    end

    // TX FIFO
    logic [7:0]       tx_mem [TX_DEPTH];
    logic [PTR_W-1:0] tx_rd_ptr;
    logic [PTR_W-1:0] tx_wr_ptr;
    logic [CNT_W-1:0] tx_count;
    logic             tx_ovf;
    logic             tx_full;
    logic             tx_empty;
    logic             tx_push;
    logic             tx_pop;
    logic             tx_push_ok;
    logic [7:0]       tx_count8;

    assign tx_empty   = (tx_count == '0);
    assign tx_full    = (tx_count == CNT_W'(TX_DEPTH));
    assign tx_push    = mmio_we && (mmio_off == OFF_TX_DATA);
    assign tx_pop     = tx_valid && tx_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign tx_push_ok = tx_push && (!tx_full || tx_pop);
    assign tx_valid   = !tx_empty;
    assign tx_data    = tx_empty ? 8'h00 : tx_mem[tx_rd_ptr];
    assign tx_count8  = 8'(tx_count);

    always_ff @(posedge clk) begin
        if (tx_push_ok)
            tx_mem[tx_wr_ptr] <= data_in[7:0];
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_rd_ptr <= '0;
            tx_wr_ptr <= '0;
            tx_count  <= '0;
            tx_ovf    <= 1'b0;
        end else begin
            if (tx_push_ok)
                tx_wr_ptr <= tx_wr_ptr + PTR_W'(1);
            if (tx_pop)
                tx_rd_ptr <= tx_rd_ptr + PTR_W'(1);
            case ({tx_push_ok, tx_pop})
                2'b10:   tx_count <= tx_count + CNT_W'(1);
                2'b01:   tx_count <= tx_count - CNT_W'(1);
                default: tx_count <= tx_count;
            endcase
            if (tx_push && tx_full && !tx_pop)
                tx_ovf <= 1'b1;
            else if (mmio_we && (mmio_off == OFF_TX_STATUS) && data_in[2])
                tx_ovf <= 1'b0;
        end
    end

    // GPIO
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            gpio_out <= '0;
        else if (mmio_we && (mmio_off == OFF_GPIO))
            gpio_out <= data_in;
    end

`ifdef DMEM_TIMER_EN
    logic [31:0] tmr_count;
    logic [31:0] tmr_cmp;
    logic        tmr_flag;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tmr_count <= '0;
            tmr_cmp   <= '1;
            tmr_flag  <= 1'b0;
        end else begin
            if (mmio_we && (mmio_off == OFF_TMR_COUNT))
                tmr_count <= data_in;
            else
                tmr_count <= tmr_count + 32'd1;
            if (mmio_we && (mmio_off == OFF_TMR_CMP))
                tmr_cmp <= data_in;
            // A match in the same cycle as a clear keeps the flag set.
            if (tmr_count == tmr_cmp)
                tmr_flag <= 1'b1;
            else if (mmio_we && (mmio_off == OFF_TMR_STATUS) && data_in[0])
                tmr_flag <= 1'b0;
        end
    end

    assign timer_irq = tmr_flag;
`else
    assign timer_irq = 1'b0;
`endif

    // Read mux
    logic [31:0] rd_word;

    // NOTE: the default assignment up front keeps this block purely combinational (no latches).
    always_comb begin
        rd_word = '0;
        if (sel_ram) begin
            rd_word = ram[ram_idx];
        end else if (sel_mmio) begin
            case (mmio_off)
                OFF_TX_STATUS:  rd_word = {16'h0, tx_count8, 5'h0, tx_ovf, tx_full, tx_empty};
                OFF_GPIO:       rd_word = gpio_out;
`ifdef DMEM_TIMER_EN
                OFF_TMR_COUNT:  rd_word = tmr_count;
                OFF_TMR_CMP:    rd_word = tmr_cmp;
                OFF_TMR_STATUS: rd_word = {31'h0, tmr_flag};
`endif
                default:        rd_word = '0;
            endcase
        end
    end

    assign data_out = (rst_n && mem_re && !mem_we) ? rd_word : 32'h0;

endmodule

// File: tb/tb_dmem_mmio.sv
// Directed self-checking bench for dmem_mmio: RAM, GPIO, TX FIFO, timer and async reset.
// Timer checks follow DMEM_TIMER_EN, so the bench works for either build.
module tb_dmem_mmio;

    localparam logic [31:0] A_TX_DATA    = 32'h1000_0000;
    localparam logic [31:0] A_TX_STATUS  = 32'h1000_0004;
    localparam logic [31:0] A_GPIO       = 32'h1000_0008;
    localparam logic [31:0] A_TMR_COUNT  = 32'h1000_000C;
    localparam logic [31:0] A_TMR_CMP    = 32'h1000_0010;
    localparam logic [31:0] A_TMR_STATUS = 32'h1000_0014;

    logic        clk;
    logic        rst_n;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_we;
    logic        mem_re;
    logic [31:0] data_out;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [31:0] gpio_out;
    logic        timer_irq;

    int n_checks = 0;
    int n_errors = 0;

    dmem_mmio #(.RAM_AW(10), .TX_DEPTH(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .data_addr (data_addr),
        .data_in   (data_in),
        .mem_we    (mem_we),
        .mem_re    (mem_re),
        .data_out  (data_out),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .gpio_out  (gpio_out),
        .timer_irq (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic store(input logic [31:0] addr, input logic [31:0] data);
        data_addr = addr;
        data_in   = data;
        mem_we    = 1'b1;
        cyc();
        mem_we    = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        data_addr = addr;
        mem_re    = 1'b1;
        #1;
        check(tag, data_out, exp);
        mem_re    = 1'b0;
    endtask

    logic [7:0] exp_bytes [4];

    initial begin
        rst_n     = 1'b0;
        data_addr = '0;
        data_in   = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        tx_ready  = 1'b0;

        // Reset state
        #2;
        check("rst_tx_valid", 32'(tx_valid), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_irq", 32'(timer_irq), 32'h0);
        check("rst_gpio", gpio_out, 32'h0);
        load_check("rst_data_out", A_TX_STATUS, 32'h0);
        #5 rst_n = 1'b1;
        cyc();
        load_check("status_after_rst", A_TX_STATUS, 32'h0000_0001);

        // RAM
        store(32'h0000_0040, 32'hDEAD_BEEF);
        load_check("ram_load", 32'h0000_0040, 32'hDEAD_BEEF);
        load_check("ram_alias", 32'h0000_1040, 32'hDEAD_BEEF);
        data_addr = 32'h0000_0040;
        mem_re    = 1'b0;
        #1 check("ram_no_re", data_out, 32'h0);
        data_in = 32'h1234_5678;
        mem_we  = 1'b1;
        mem_re  = 1'b1;
        #1 check("we_re_zero", data_out, 32'h0);
        cyc();
        mem_we = 1'b0;
        mem_re = 1'b0;
        load_check("we_re_write_done", 32'h0000_0040, 32'h1234_5678);

        // GPIO and unmapped space
        store(A_GPIO, 32'h0000_A5A5);
        check("gpio_out", gpio_out, 32'h0000_A5A5);
        load_check("gpio_read", A_GPIO, 32'h0000_A5A5);
        load_check("unmapped_region", 32'h2000_0000, 32'h0);
        load_check("unmapped_offset", 32'h1000_0018, 32'h0);

        // FIFO fill with overflow
        check("fifo_empty_valid", 32'(tx_valid), 32'h0);
        store(A_TX_DATA, 32'h0000_0011);
        check("first_push_valid", 32'(tx_valid), 32'h1);
        store(A_TX_DATA, 32'h0000_0022);
        store(A_TX_DATA, 32'h0000_0033);
        store(A_TX_DATA, 32'h0000_0044);
        store(A_TX_DATA, 32'h0000_0055);
        load_check("status_full_ovf", A_TX_STATUS, 32'h0000_0406);
        check("head_byte", 32'(tx_data), 32'h11);
        load_check("tx_data_reads_0", A_TX_DATA, 32'h0);

        // Drain
        exp_bytes = '{8'h11, 8'h22, 8'h33, 8'h44};
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_valid%0d", i), 32'(tx_valid), 32'h1);
            check($sformatf("drain_byte%0d", i), 32'(tx_data), 32'(exp_bytes[i]));
            cyc();
        end
        check("drained_valid", 32'(tx_valid), 32'h0);
        check("drained_data", 32'(tx_data), 32'h0);
        tx_ready = 1'b0;
        load_check("status_ovf_sticky", A_TX_STATUS, 32'h0000_0005);
        store(A_TX_STATUS, 32'h0000_0004);
        load_check("status_ovf_clear", A_TX_STATUS, 32'h0000_0001);

        // Simultaneous push and pop while full
        store(A_TX_DATA, 32'h0000_00A1);
        store(A_TX_DATA, 32'h0000_00A2);
        store(A_TX_DATA, 32'h0000_00A3);
        store(A_TX_DATA, 32'h0000_00A4);
        tx_ready  = 1'b1;
        data_addr = A_TX_DATA;
        data_in   = 32'h0000_00B5;
        mem_we    = 1'b1;
        #1 check("pushpop_head", 32'(tx_data), 32'hA1);
        cyc();
        mem_we   = 1'b0;
        tx_ready = 1'b0;
        load_check("pushpop_status", A_TX_STATUS, 32'h0000_0402);
        exp_bytes = '{8'hA2, 8'hA3, 8'hA4, 8'hB5};
        tx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("pp_byte%0d", i), 32'(tx_data), 32'(exp_bytes[i]));
            cyc();
        end
        check("pp_empty", 32'(tx_valid), 32'h0);
        tx_ready = 1'b0;

`ifdef DMEM_TIMER_EN
        // Timer match
        store(A_TMR_CMP, 32'd20);
        load_check("tmr_cmp_read", A_TMR_CMP, 32'd20);
        store(A_TMR_COUNT, 32'd15);
        check("irq_low_at_load", 32'(timer_irq), 32'h0);
        for (int i = 1; i <= 6; i++) begin
            cyc();
            check($sformatf("irq_cycle%0d", i), 32'(timer_irq), (i == 6) ? 32'h1 : 32'h0);
        end
        load_check("tmr_status", A_TMR_STATUS, 32'h1);
        load_check("tmr_count_run", A_TMR_COUNT, 32'd21);
        store(A_TMR_STATUS, 32'h1);
        check("irq_w1c", 32'(timer_irq), 32'h0);

        // Wrap
        store(A_TMR_COUNT, 32'hFFFF_FFFF);
        load_check("tmr_pre_wrap", A_TMR_COUNT, 32'hFFFF_FFFF);
        cyc();
        load_check("tmr_wrap", A_TMR_COUNT, 32'h0);

        // Set the flag for the reset test
        store(A_TMR_COUNT, 32'd20);
        cyc();
        check("irq_before_reset", 32'(timer_irq), 32'h1);
`else
        store(A_TMR_COUNT, 32'd5);
        load_check("notmr_count", A_TMR_COUNT, 32'h0);
        store(A_TMR_CMP, 32'd5);
        load_check("notmr_cmp", A_TMR_CMP, 32'h0);
        load_check("notmr_status", A_TMR_STATUS, 32'h0);
        check("notmr_irq", 32'(timer_irq), 32'h0);
`endif

        // Asynchronous reset mid-drain
        store(A_TX_DATA, 32'h0000_00C1);
        store(A_TX_DATA, 32'h0000_00C2);
        store(A_TX_DATA, 32'h0000_00C3);
        tx_ready = 1'b1;
        cyc();
        check("mid_drain_head", 32'(tx_data), 32'hC2);
        #2 rst_n = 1'b0;
        #1;
        check("async_tx_valid", 32'(tx_valid), 32'h0);
        check("async_tx_data", 32'(tx_data), 32'h0);
        check("async_irq", 32'(timer_irq), 32'h0);
        check("async_gpio", gpio_out, 32'h0);
        load_check("async_data_out", 32'h0000_0040, 32'h0);
        #1 rst_n = 1'b1;
        tx_ready = 1'b0;
        cyc();
        check("post_rst_valid", 32'(tx_valid), 32'h0);
        load_check("post_rst_status", A_TX_STATUS, 32'h0000_0001);
        load_check("ram_preserved", 32'h0000_0040, 32'h1234_5678);
        load_check("post_rst_gpio", A_GPIO, 32'h0);
`ifdef DMEM_TIMER_EN
        load_check("post_rst_cmp", A_TMR_CMP, 32'hFFFF_FFFF);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "bench timed out");
    end

endmodule
